// File: rtl/button_pulse_gen.sv
`timescale 1ns/1ps
// button_pulse_gen: turns a raw bouncy push-button pad into debounced press, release and long-press events
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES   = 10000,
    parameter int LONG_PRESS_CYCLES = 5000000,
    localparam int CNT_W = $clog2(LONG_PRESS_CYCLES + 1)
) (
    input  logic system_clk,
    input  logic rst,
    input  logic button_raw,
    output logic press_pulse,
    output logic release_pulse,
    output logic held,
    output logic long_press_pulse
);
    typedef enum logic [1:0] {IDLE, ARM, PRESSED, DISARM} state_t;
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(LONG_PRESS_CYCLES);
    state_t state, state_n;
    logic sync_0, sync_in;
    logic [CNT_W-1:0] dcnt, dcnt_n, lcnt, lcnt_n, lcnt_inc;
    logic press_n, release_n, held_n, long_n, d_done;
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            sync_0           <= 1'b0;
            sync_in          <= 1'b0;
            state            <= IDLE;
            dcnt             <= '0;
            lcnt             <= '0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            held             <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            sync_0           <= button_raw;
            sync_in          <= sync_0;
            state            <= state_n;
            dcnt             <= dcnt_n;
            lcnt             <= lcnt_n;
            press_pulse      <= press_n;
            release_pulse    <= release_n;
            held             <= held_n;
            long_press_pulse <= long_n;
        end
    end
    // lcnt keeps running through DISARM so a release bounce cannot re-arm the long press
    always_comb begin
        state_n   = state;
        dcnt_n    = dcnt;
        lcnt_n    = lcnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        held_n    = held;
        lcnt_inc  = (lcnt == L_MAX) ? lcnt : lcnt + CNT_W'(1);
        d_done    = dcnt == D_LAST;
        case (state)
            IDLE: if (sync_in) begin
                state_n = ARM;
                dcnt_n  = '0;
            end
            ARM: if (!sync_in) state_n = IDLE;
            else if (d_done) begin
                state_n = PRESSED;
                press_n = 1'b1;
                held_n  = 1'b1;
                lcnt_n  = '0;
            end else dcnt_n = dcnt + CNT_W'(1);
            PRESSED: begin
                lcnt_n = lcnt_inc;
                long_n = lcnt_inc == L_LAST;
                if (!sync_in) begin
                    state_n = DISARM;
                    dcnt_n  = '0;
                end
            end
            DISARM: begin
                lcnt_n = lcnt_inc;
                if (sync_in) state_n = PRESSED;
                else if (d_done) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                    held_n    = 1'b0;
                end else dcnt_n = dcnt + CNT_W'(1);
                long_n = (lcnt_inc == L_LAST) && !release_n;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_button_pulse_gen.sv
`timescale 1ns/1ps
// tb_button_pulse_gen: table of raw-input segments with expected pulse edges, checked by a pulse scoreboard
module tb_button_pulse_gen;
    logic system_clk = 1'b0, rst = 1'b1, button_raw = 1'b1;
    logic press_pulse, release_pulse, held, long_press_pulse;
    int edge_n = 0, n_vec = 0, n_bad = 0;
    typedef struct {logic raw; int cycles; int p_off; int l_off; int r_off; logic held_end;} vec_t;
    typedef struct {int kind; int at;} evt_t;
    evt_t sb[$];
    vec_t tbl[11];
    vec_t v_press;

    button_pulse_gen #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20)) dut (
        .system_clk(system_clk),
        .rst(rst),
        .button_raw(button_raw),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .held(held),
        .long_press_pulse(long_press_pulse)
    );

    always #5 system_clk = ~system_clk;
    always @(posedge system_clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    task automatic chk_evt(input int kind);
        evt_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_pulse: got kind %0d at edge %0d, required none", kind, edge_n);
        end else begin
            e = sb.pop_front();
            chk("pulse_kind", kind, e.kind);
            chk("pulse_edge", edge_n, e.at);
        end
    endtask

    // kinds: 0 press, 1 long press, 2 release
    always @(negedge system_clk) begin
        if (press_pulse) chk_evt(0);
        if (long_press_pulse) chk_evt(1);
        if (release_pulse) chk_evt(2);
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_press"}, int'(press_pulse), 0);
        chk({tag, "_release"}, int'(release_pulse), 0);
        chk({tag, "_held"}, int'(held), 0);
        chk({tag, "_long"}, int'(long_press_pulse), 0);
    endtask

    task automatic run_row(input vec_t v);
        int s;
        s = edge_n + 1;
        button_raw = v.raw;
        if (v.p_off >= 0) sb.push_back('{0, s + v.p_off});
        if (v.l_off >= 0) sb.push_back('{1, s + v.l_off});
        if (v.r_off >= 0) sb.push_back('{2, s + v.r_off});
        repeat (v.cycles) @(negedge system_clk);
        chk("held_row", int'(held), int'(v.held_end));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 10,  6, -1, -1, 1'b1};
        tbl[1]  = '{1'b0, 10, -1, -1,  6, 1'b0};
        tbl[2]  = '{1'b1,  2, -1, -1, -1, 1'b0};
        tbl[3]  = '{1'b0,  6, -1, -1, -1, 1'b0};
        tbl[4]  = '{1'b1, 10,  6, -1, -1, 1'b1};
        tbl[5]  = '{1'b0,  2, -1, -1, -1, 1'b1};
        tbl[6]  = '{1'b1,  6, -1, -1, -1, 1'b1};
        tbl[7]  = '{1'b0, 10, -1, -1,  6, 1'b0};
        tbl[8]  = '{1'b1, 30,  6, 25, -1, 1'b1};
        tbl[9]  = '{1'b1, 20, -1, -1, -1, 1'b1};
        tbl[10] = '{1'b0, 10, -1, -1,  6, 1'b0};
        v_press = '{1'b1, 10,  6, -1, -1, 1'b1};
        repeat (3) @(negedge system_clk);
        chk_zero("reset");
        rst = 1'b0;
        foreach (tbl[i]) run_row(tbl[i]);
        button_raw = 1'b1;
        repeat (4) @(negedge system_clk);
        #2 rst = 1'b1;
        #1 chk_zero("rst_in_arm");
        button_raw = 1'b0;
        repeat (2) @(negedge system_clk);
        rst = 1'b0;
        repeat (12) @(negedge system_clk);
        run_row(v_press);
        #2 rst = 1'b1;
        #1 chk_zero("rst_in_pressed");
        button_raw = 1'b0;
        repeat (2) @(negedge system_clk);
        rst = 1'b0;
        repeat (12) @(negedge system_clk);
        chk("missing_pulses", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
